// File: rtl/bypass_tracker.sv
// bypass_tracker: tracks EXE/MEM/WB register-write bypass state for a 3-stage back end
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   id_to_exe_valid, id_rf_w_en,
//   id_rf_w_addr, id_is_load          instruction offered to EXE
//   exe_res_valid, exe_res, exe_stall ALU result return and external EXE hold
//   mem_rdata_valid, mem_rdata        load data return for the MEM instruction
//   flush                             kill EXE and MEM
//   exe_allowin                       EXE accepts the offered instruction this cycle
//   BY_to_WK_bus                      {addr, dv, wen} of EXE, MEM, WB (MSB first)
//   exe_w_data, mem_w_data, wb_w_data bypass data held per stage
module bypass_tracker #(
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               id_to_exe_valid,
  input  logic               id_rf_w_en,
  input  logic [4:0]         id_rf_w_addr,
  input  logic               id_is_load,
  input  logic               exe_res_valid,
  input  logic [DATA_WD-1:0] exe_res,
  input  logic               exe_stall,
  input  logic               mem_rdata_valid,
  input  logic [DATA_WD-1:0] mem_rdata,
  input  logic               flush,
  output logic               exe_allowin,
  output logic [20:0]        BY_to_WK_bus,
  output logic [DATA_WD-1:0] exe_w_data,
  output logic [DATA_WD-1:0] mem_w_data,
  output logic [DATA_WD-1:0] wb_w_data
);
  logic               exe_valid, exe_w_en, exe_is_load, exe_dv;
  logic [4:0]         exe_addr;
  logic [DATA_WD-1:0] exe_data;
  logic               mem_valid, mem_w_en, mem_is_load, mem_dv;
  logic [4:0]         mem_addr;
  logic [DATA_WD-1:0] mem_data;
  logic               wb_valid, wb_w_en, wb_is_load, wb_dv;
  logic [4:0]         wb_addr;
  logic [DATA_WD-1:0] wb_data;
  logic               exe_ready_go, mem_ready_go, mem_allowin;
  logic               exe_cap, mem_cap, exe_go, mem_go, entry;
  logic               exe_dv_n;
  logic [DATA_WD-1:0] exe_data_n;
  logic               exe_wen, mem_wen, wb_wen;
  always_comb begin
    exe_ready_go = (exe_dv | exe_is_load) & ~exe_stall;
    mem_ready_go = mem_dv;
    mem_allowin  = ~mem_valid | mem_ready_go;
    exe_allowin  = ~exe_valid | (exe_ready_go & mem_allowin);
    exe_go       = exe_valid & exe_ready_go & mem_allowin;
    mem_go       = mem_valid & mem_ready_go;
    entry        = id_to_exe_valid & exe_allowin;
    // loads never take an ALU result; only the first result pulse is kept
    exe_cap      = exe_valid & exe_res_valid & ~exe_is_load & ~exe_dv;
    mem_cap      = mem_valid & mem_rdata_valid & ~mem_dv;
    // EXE contents after this edge's capture, used both in place and when moving to MEM
    exe_dv_n     = exe_dv | exe_cap;
    exe_data_n   = exe_cap ? exe_res : exe_data;
    exe_wen      = exe_valid & exe_w_en & (exe_addr != 5'd0);
    mem_wen      = mem_valid & mem_w_en & (mem_addr != 5'd0);
    wb_wen       = wb_valid & wb_w_en & (wb_addr != 5'd0);
    BY_to_WK_bus = {exe_addr, exe_dv, exe_wen, mem_addr, mem_dv, mem_wen, wb_addr, wb_dv, wb_wen};
    exe_w_data   = exe_data;
    mem_w_data   = mem_data;
    wb_w_data    = wb_data;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid   <= 1'b0;
      exe_w_en    <= 1'b0;
      exe_is_load <= 1'b0;
      exe_dv      <= 1'b0;
      exe_addr    <= '0;
      exe_data    <= '0;
      mem_valid   <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_is_load <= 1'b0;
      mem_dv      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      wb_valid    <= 1'b0;
      wb_w_en     <= 1'b0;
      wb_is_load  <= 1'b0;
      wb_dv       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
    end else begin
      // WB always retires; a MEM->WB move completes even under flush
      wb_valid <= mem_go;
      if (mem_go) begin
        wb_w_en    <= mem_w_en;
        wb_is_load <= mem_is_load;
        wb_dv      <= mem_dv;
        wb_addr    <= mem_addr;
        wb_data    <= mem_data;
      end
      // flush kills EXE/MEM, drops any entry and freezes their remaining fields
      if (flush) begin
        exe_valid <= 1'b0;
        mem_valid <= 1'b0;
      end else begin
        if (exe_go) begin
          mem_valid   <= 1'b1;
          mem_w_en    <= exe_w_en;
          mem_is_load <= exe_is_load;
          mem_dv      <= exe_dv_n;
          mem_addr    <= exe_addr;
          mem_data    <= exe_data_n;
        end else begin
          mem_valid <= mem_valid & ~mem_go;
          if (mem_cap) begin
            mem_dv   <= 1'b1;
            mem_data <= mem_rdata;
          end
        end
        if (entry) begin
          exe_valid   <= 1'b1;
          exe_w_en    <= id_rf_w_en;
          exe_is_load <= id_is_load;
          exe_addr    <= id_rf_w_addr;
          exe_dv      <= 1'b0;
        end else begin
          exe_valid <= exe_valid & ~exe_go;
          exe_dv    <= exe_dv_n;
          exe_data  <= exe_data_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_bypass_tracker.sv
// tb_bypass_tracker: directed literal checks plus randomized run against a record-level pipeline model
module tb_bypass_tracker;
  logic        clk = 0;
  logic        resetn = 0;
  logic        id_to_exe_valid = 0, id_rf_w_en = 0, id_is_load = 0;
  logic [4:0]  id_rf_w_addr = 0;
  logic        exe_res_valid = 0, exe_stall = 0, mem_rdata_valid = 0, flush = 0;
  logic [31:0] exe_res = 0, mem_rdata = 0;
  logic        exe_allowin;
  logic [20:0] BY_to_WK_bus;
  logic [31:0] exe_w_data, mem_w_data, wb_w_data;

  always #5 clk = ~clk;

  bypass_tracker #(.DATA_WD(32)) dut (
    .clk(clk), .resetn(resetn),
    .id_to_exe_valid(id_to_exe_valid), .id_rf_w_en(id_rf_w_en),
    .id_rf_w_addr(id_rf_w_addr), .id_is_load(id_is_load),
    .exe_res_valid(exe_res_valid), .exe_res(exe_res), .exe_stall(exe_stall),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .flush(flush),
    .exe_allowin(exe_allowin), .BY_to_WK_bus(BY_to_WK_bus),
    .exe_w_data(exe_w_data), .mem_w_data(mem_w_data), .wb_w_data(wb_w_data)
  );

  typedef struct packed {
    logic        v, w, ld, dv;
    logic [4:0]  a;
    logic [31:0] d;
  } slot_t;

  slot_t st [3];
  int errors = 0, checks = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] fld(input slot_t s);
    return {s.a, s.dv, s.v && s.w && (s.a != 5'd0)};
  endfunction

  function automatic logic [20:0] model_bus();
    return {fld(st[0]), fld(st[1]), fld(st[2])};
  endfunction

  function automatic logic model_allowin();
    logic mem_free;
    mem_free = !st[1].v || st[1].dv;
    return !st[0].v || ((st[0].dv || st[0].ld) && !exe_stall && mem_free);
  endfunction

  function automatic logic [20:0] mkb(input logic [4:0] ea, input logic edv, input logic ewen,
                                      input logic [4:0] ma, input logic mdv, input logic mwen,
                                      input logic [4:0] wa, input logic wdv, input logic wwen);
    return {ea, edv, ewen, ma, mdv, mwen, wa, wdv, wwen};
  endfunction

  // One clock of the pipeline, stated on whole slot records
  task automatic model_step();
    slot_t e, m, nx [3];
    logic ego, mgo;
    if (!resetn) begin
      for (int i = 0; i < 3; i++) st[i] = '0;
      return;
    end
    e = st[0];
    m = st[1];
    if (e.v && !e.ld && !e.dv && exe_res_valid) begin e.dv = 1; e.d = exe_res; end
    if (m.v && !m.dv && mem_rdata_valid) begin m.dv = 1; m.d = mem_rdata; end
    mgo = st[1].v && st[1].dv;
    ego = st[0].v && (st[0].dv || st[0].ld) && !exe_stall && (!st[1].v || st[1].dv);
    nx[2] = mgo ? st[1] : st[2];
    nx[2].v = mgo;
    if (flush) begin
      nx[0] = st[0]; nx[0].v = 0;
      nx[1] = st[1]; nx[1].v = 0;
    end else begin
      nx[1] = ego ? e : m;
      if (!ego && mgo) nx[1].v = 0;
      nx[0] = e;
      if (ego) nx[0].v = 0;
      if (id_to_exe_valid && model_allowin()) begin
        nx[0].v = 1; nx[0].w = id_rf_w_en; nx[0].ld = id_is_load;
        nx[0].a = id_rf_w_addr; nx[0].dv = 0; nx[0].d = st[0].d;
      end
    end
    for (int i = 0; i < 3; i++) st[i] = nx[i];
  endtask

  initial for (int i = 0; i < 3; i++) st[i] = '0;

  always @(posedge clk) model_step();

  always begin
    @(negedge clk);
    #2;
    if (chk_on) begin
      chk("bus", {11'd0, BY_to_WK_bus}, {11'd0, model_bus()});
      chk("exe_allowin", {31'd0, exe_allowin}, {31'd0, model_allowin()});
      chk("exe_w_data", exe_w_data, st[0].d);
      chk("mem_w_data", mem_w_data, st[1].d);
      chk("wb_w_data", wb_w_data, st[2].d);
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic idle();
    id_to_exe_valid = 0; id_rf_w_en = 0; id_rf_w_addr = 0; id_is_load = 0;
    exe_res_valid = 0; mem_rdata_valid = 0; flush = 0; exe_stall = 0;
  endtask

  task automatic offer(input logic w, input logic [4:0] a, input logic ld);
    idle();
    id_to_exe_valid = 1; id_rf_w_en = w; id_rf_w_addr = a; id_is_load = ld;
  endtask

  task automatic lit(input string name, input logic [20:0] exp);
    chk(name, {11'd0, BY_to_WK_bus}, {11'd0, exp});
  endtask

  initial begin
    idle();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
    chk_on = 1;
    lit("reset_bus", 21'd0);
    chk("reset_allowin", {31'd0, exe_allowin}, 32'd1);
    chk("reset_wb_data", wb_w_data, 32'd0);

    offer(1, 5, 0); tick();
    lit("alu_enter", mkb(5, 0, 1, 0, 0, 0, 0, 0, 0));
    idle(); exe_res_valid = 1; exe_res = 32'h1234; tick();
    lit("alu_exe_dv", mkb(5, 1, 1, 0, 0, 0, 0, 0, 0));
    chk("alu_exe_data", exe_w_data, 32'h1234);
    idle(); tick();
    lit("alu_mem", mkb(5, 1, 0, 5, 1, 1, 0, 0, 0));
    chk("alu_mem_data", mem_w_data, 32'h1234);
    tick();
    lit("alu_wb", mkb(5, 1, 0, 5, 1, 0, 5, 1, 1));
    chk("alu_wb_data", wb_w_data, 32'h1234);
    tick();
    lit("alu_retired", mkb(5, 1, 0, 5, 1, 0, 5, 1, 0));

    offer(1, 7, 1); tick();
    lit("ld_enter", mkb(7, 0, 1, 5, 1, 0, 5, 1, 0));
    offer(1, 9, 0); tick();
    lit("ld_mem_dv0", mkb(9, 0, 1, 7, 0, 1, 5, 1, 0));
    chk("ld_allowin_refilled", {31'd0, exe_allowin}, 32'd0);
    idle(); exe_res_valid = 1; exe_res = 32'h55; tick();
    lit("ld_mem_hold", mkb(9, 1, 1, 7, 0, 1, 5, 1, 0));
    chk("ld_allowin_held", {31'd0, exe_allowin}, 32'd0);
    idle(); mem_rdata_valid = 1; mem_rdata = 32'hCAFE; tick();
    lit("ld_mem_dv1", mkb(9, 1, 1, 7, 1, 1, 5, 1, 0));
    chk("ld_mem_data", mem_w_data, 32'hCAFE);
    idle(); tick();
    lit("ld_wb", mkb(9, 1, 0, 9, 1, 1, 7, 1, 1));
    chk("ld_wb_data", wb_w_data, 32'hCAFE);
    tick();
    lit("alu2_wb", mkb(9, 1, 0, 9, 1, 0, 9, 1, 1));
    tick();

    offer(1, 0, 0); tick();
    lit("r0_exe", mkb(0, 0, 0, 9, 1, 0, 9, 1, 0));
    idle(); exe_res_valid = 1; exe_res = 32'h77; tick();
    lit("r0_exe_dv", mkb(0, 1, 0, 9, 1, 0, 9, 1, 0));
    idle(); tick();
    lit("r0_mem", mkb(0, 1, 0, 0, 1, 0, 9, 1, 0));
    tick();
    lit("r0_wb", mkb(0, 1, 0, 0, 1, 0, 0, 1, 0));
    chk("r0_wb_data", wb_w_data, 32'h77);

    offer(1, 3, 1); tick();
    offer(1, 4, 0); tick();
    lit("fl_setup", mkb(4, 0, 1, 3, 0, 1, 0, 1, 0));
    idle(); mem_rdata_valid = 1; mem_rdata = 32'hBEEF; exe_res_valid = 1; exe_res = 32'h44; tick();
    lit("fl_full", mkb(4, 1, 1, 3, 1, 1, 0, 1, 0));
    offer(1, 6, 0); flush = 1; #1;
    chk("fl_allowin", {31'd0, exe_allowin}, 32'd1);
    tick();
    chk("fl_wens", {29'd0, BY_to_WK_bus[14], BY_to_WK_bus[7], BY_to_WK_bus[0]}, 32'd1);
    chk("fl_wb_fields", {25'd0, BY_to_WK_bus[6:0]}, {25'd0, 5'd3, 2'b11});
    chk("fl_wb_data", wb_w_data, 32'hBEEF);
    idle(); tick();
    chk("fl_after_wens", {29'd0, BY_to_WK_bus[14], BY_to_WK_bus[7], BY_to_WK_bus[0]}, 32'd0);

    offer(1, 10, 1); tick();
    offer(1, 11, 1); tick();
    idle(); mem_rdata_valid = 1; mem_rdata = 32'hD00D; tick();
    offer(1, 12, 1); tick();
    lit("mid_full", mkb(12, 0, 1, 11, 0, 1, 10, 1, 1));
    idle(); resetn = 0; tick();
    resetn = 1;
    lit("mid_reset_bus", 21'd0);
    chk("mid_reset_allowin", {31'd0, exe_allowin}, 32'd1);
    chk("mid_reset_data", exe_w_data | mem_w_data | wb_w_data, 32'd0);

    for (int n = 0; n < 4000; n++) begin
      resetn          = ($urandom_range(0, 99) != 0);
      flush           = ($urandom_range(0, 19) == 0);
      exe_stall       = ($urandom_range(0, 4) == 0);
      id_to_exe_valid = ($urandom_range(0, 9) < 6);
      id_rf_w_en      = ($urandom_range(0, 3) != 0);
      id_rf_w_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      id_is_load      = ($urandom_range(0, 2) == 0);
      exe_res_valid   = ($urandom_range(0, 9) < 4);
      exe_res         = $urandom;
      mem_rdata_valid = ($urandom_range(0, 9) < 4);
      mem_rdata       = $urandom;
      tick();
    end
    idle();
    resetn = 1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
